pwm11_decode: RTL and testbench
===============================

PWM11_DECODE -- requirements
Module: pwm11_decode

Interface
REQ-001 Parameter DUTY_W, default 11, is the duty and high-count width; the nominal period is 2**DUTY_W clocks.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 PWM_in  input  1  asynchronous PWM waveform, 2048-clock period, high for duty clocks per period.
REQ-005 duty  output  DUTY_W  last successfully decoded duty value, held between updates.
REQ-006 vld  output  1  one-cycle pulse when duty is updated.
REQ-007 err  output  1  one-cycle pulse on a malformed period (wrong length or stuck-high).

Function
REQ-008 PWM_in passes through a 2-flop synchronizer, then a third flop for edge detect; s = synchronized level; rise = s & ~s_prev.
REQ-009 FSM has two states: HUNT (no phase reference) and MEASURE (counting since last rise).
REQ-010 Counters: per_cnt 12 bits, saturating at 4095; hi_cnt DUTY_W bits; run_cnt 12 bits, counting consecutive equal-level cycles in HUNT.
REQ-011 HUNT, rise: go to MEASURE; per_cnt=1; hi_cnt=1.
REQ-012 HUNT, no rise: run_cnt increments while s is unchanged and resets to 1 on any level change.
REQ-013 HUNT, run_cnt reaches 2048 with s=0: duty<=0, vld=1, run_cnt restarts at 0; vld repeats every 2048 low cycles.
REQ-014 HUNT, run_cnt reaches 2048 with s=1: err=1, run_cnt restarts at 0; duty unchanged.
REQ-015 MEASURE, no rise: per_cnt+1; hi_cnt+s.
REQ-016 MEASURE, rise with per_cnt==2048: duty<=hi_cnt, vld=1; per_cnt=1, hi_cnt=1; stay in MEASURE.
REQ-017 MEASURE, rise with per_cnt!=2048: err=1, duty unchanged; per_cnt=1, hi_cnt=1; stay in MEASURE.
REQ-018 MEASURE, per_cnt reaches 2049 without rise: err=1; go to HUNT; run_cnt=0.
REQ-019 vld and err are never asserted in the same cycle; each is registered.
REQ-020 Latency: vld asserts exactly 3 clk after the PWM_in rise that closes a valid period (2 sync + 1 output register).
REQ-021 duty=2047: low one clock per period; decode returns 2047, max hi_cnt, no overflow.
REQ-022 First rise after reset or after HUNT only establishes phase; no vld until the next rise.

Reset
REQ-023 While rst=1 at a clk edge, set: state=HUNT; duty=0; vld=0; err=0; all counters=0; sync and edge flops=0.
REQ-024 rst asserted mid-MEASURE discards the partial measurement; the next decode requires a fresh rise plus a full period.

Structure
REQ-025 Shared package pwm_pkg holds PWM_PERIOD=2048, DUTY_W=11, and the state enum (HUNT, MEASURE) for use by pwm11_decode and benches.
REQ-026 One sub-module: pwm_in_sync (2-flop synchronizer plus edge-detect flop, outputs s and rise), synchronous active-high reset.
REQ-027 Everything else lives in pwm11_decode as one always_ff and combinational next-state logic.

Verification
REQ-028 Drive a 2048-period PWM with duty=1024 -> after the second rise, vld=1 and duty=1024, repeating every 2048 clk.
REQ-029 duty=0 (PWM_in held low) -> vld=1 and duty=0 at 2048 low cycles after sync, then every 2048 clk; err never asserts.
REQ-030 duty=2047 -> duty=2047 with vld each period; then duty=1 -> duty=1 on the following period.
REQ-031 Period of 1000 clk, duty=500 -> err pulses each rise, vld stays 0, duty holds its prior value; a rise 2100 clk after the last rise -> err at per_cnt 2049, FSM in HUNT.
REQ-032 PWM_in held high for 3000 clk -> exactly one err pulse 2048 clk after the HUNT run starts; duty unchanged.
REQ-033 Assert rst for 1 clk in mid-period while duty=700 -> next cycle duty=0, vld=0; first vld reports 700 only after two subsequent rises.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and FSM state type for the PWM duty decoder
// and its benches.
//   PWM_PERIOD  nominal PWM period in clk cycles
//   DUTY_W      duty / high-count width (period = 2**DUTY_W)
//   pwm_state_e decoder FSM states
package pwm_pkg;

  localparam int PWM_PERIOD = 2048;
  localparam int DUTY_W     = 11;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    MEASURE = 1'b1
  } pwm_state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// pwm_in_sync: brings the asynchronous PWM input into the clk domain and
// flags its rising edges.
//   clk      sole clock, rising edge
//   rst      synchronous, active-high reset; clears all three flops
//   pwm_raw  asynchronous PWM waveform
//   s        synchronized level (second synchronizer flop)
//   rise     one-cycle strobe, s is high and was low the cycle before
module pwm_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic pwm_raw,
  output logic s,
  output logic rise
);

  logic meta;
  logic s_q;
  logic s_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      s_q    <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      meta   <= pwm_raw;
      s_q    <= meta;
      s_prev <= s_q;
    end
  end

  assign s    = s_q;
  assign rise = s_q & ~s_prev;

endmodule

// File: rtl/pwm11_decode.sv
// pwm11_decode: recovers the duty value of a fixed-period PWM waveform.
// Each rising edge closes the previous period; a period is accepted only
// if it is exactly 2**DUTY_W clocks long, in which case the number of high
// clocks in it becomes the new duty. A line that stays low for a full
// period decodes as duty 0; a line stuck high or a wrong-length period
// raises err.
//   clk     sole clock, rising edge
//   rst     synchronous, active-high reset
//   PWM_in  asynchronous PWM waveform
//   duty    last decoded duty, held between updates
//   vld     one-cycle pulse when duty is updated
//   err     one-cycle pulse on a malformed period
//
// state   | meaning
// --------+-----------------------------------------------------------
// HUNT    | no phase reference; waiting for a rise, timing level runs
// MEASURE | counting clocks and high clocks since the last rise
module pwm11_decode #(
  parameter int DUTY_W = pwm_pkg::DUTY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PWM_in,
  output logic [DUTY_W-1:0] duty,
  output logic              vld,
  output logic              err
);

  import pwm_pkg::pwm_state_e;
  import pwm_pkg::HUNT;
  import pwm_pkg::MEASURE;

  // One extra bit so a full period (2**DUTY_W) and its overrun are
  // representable in the period and run counters.
  localparam int CNT_W = DUTY_W + 1;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  PER_LEN  = CNT_W'(1) << DUTY_W;
  localparam logic [CNT_W-1:0]  RUN_LAST = PER_LEN - CNT_ONE;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [DUTY_W-1:0] HI_ONE   = DUTY_W'(1);

  logic s;
  logic rise;

  pwm_in_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .pwm_raw (PWM_in),
    .s       (s),
    .rise    (rise)
  );

  pwm_state_e        state;
  pwm_state_e        state_nxt;
  logic [CNT_W-1:0]  per_cnt;
  logic [CNT_W-1:0]  per_nxt;
  logic [DUTY_W-1:0] hi_cnt;
  logic [DUTY_W-1:0] hi_nxt;
  logic [CNT_W-1:0]  run_cnt;
  logic [CNT_W-1:0]  run_nxt;
  logic              run_lvl;
  logic              run_lvl_nxt;
  logic [DUTY_W-1:0] duty_nxt;
  logic              vld_nxt;
  logic              err_nxt;

  always_comb begin
    state_nxt   = state;
    per_nxt     = per_cnt;
    hi_nxt      = hi_cnt;
    run_nxt     = run_cnt;
    run_lvl_nxt = run_lvl;
    duty_nxt    = duty;
    vld_nxt     = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      HUNT: begin
        if (rise) begin
          // The rise clock itself is high, so the high count starts at 1.
          state_nxt = MEASURE;
          per_nxt   = CNT_ONE;
          hi_nxt    = HI_ONE;
        end else if (s != run_lvl) begin
          run_nxt     = CNT_ONE;
          run_lvl_nxt = s;
        end else if (run_cnt == RUN_LAST) begin
          // This clock completes a full period at one level.
          run_nxt = '0;
          if (s) begin
            err_nxt = 1'b1;
          end else begin
            vld_nxt  = 1'b1;
            duty_nxt = '0;
          end
        end else begin
          run_nxt = run_cnt + CNT_ONE;
        end
      end

      MEASURE: begin
        if (rise) begin
          if (per_cnt == PER_LEN) begin
            duty_nxt = hi_cnt;
            vld_nxt  = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
          per_nxt = CNT_ONE;
          hi_nxt  = HI_ONE;
        end else if (per_cnt == PER_LEN) begin
          // Period overrun: phase is lost, fall back to level timing.
          err_nxt     = 1'b1;
          state_nxt   = HUNT;
          per_nxt     = per_cnt + CNT_ONE;
          run_nxt     = '0;
          run_lvl_nxt = s;
        end else begin
          per_nxt = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_ONE;
          hi_nxt  = hi_cnt + {{(DUTY_W-1){1'b0}}, s};
        end
      end

      default: begin
        state_nxt = HUNT;
        run_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HUNT;
      per_cnt <= '0;
      hi_cnt  <= '0;
      run_cnt <= '0;
      run_lvl <= 1'b0;
      duty    <= '0;
      vld     <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      per_cnt <= per_nxt;
      hi_cnt  <= hi_nxt;
      run_cnt <= run_nxt;
      run_lvl <= run_lvl_nxt;
      duty    <= duty_nxt;
      vld     <= vld_nxt;
      err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pwm11_decode.sv
module tb_pwm11_decode;
  import pwm_pkg::*;

  localparam int          P  = PWM_PERIOD;
  localparam int unsigned PU = PWM_PERIOD;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              PWM_in = 1'b0;
  logic [DUTY_W-1:0] duty;
  logic              vld;
  logic              err;

  pwm11_decode #(.DUTY_W(DUTY_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .PWM_in (PWM_in),
    .duty   (duty),
    .vld    (vld),
    .err    (err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int nprint      = 0;
  int n_vld       = 0;
  int n_err       = 0;

  // Reference model: works from timestamps of rises and level runs and
  // re-sums the stored level history over each closed period.
  bit                d0, d1, d2;
  bit                lvl_hist [4096];
  bit                measuring;
  bit                run_ok;
  bit                run_lvl;
  int unsigned       m_cyc;
  int unsigned       t_rise;
  int unsigned       run_start;
  logic [DUTY_W-1:0] e_duty;
  bit                e_vld;
  bit                e_err;

  function automatic void model_step();
    bit lv, pv;
    int sum;
    lv = d1;
    pv = d2;
    m_cyc++;
    e_vld = 1'b0;
    e_err = 1'b0;
    if (rst) begin
      d0 = 1'b0; d1 = 1'b0; d2 = 1'b0;
      measuring = 1'b0;
      run_ok    = 1'b0;
      e_duty    = '0;
    end else begin
      d2 = d1; d1 = d0; d0 = PWM_in;
      lvl_hist[m_cyc[11:0]] = lv;
      if (measuring) begin
        if (lv && !pv) begin
          if (m_cyc - t_rise == PU) begin
            sum = 0;
            for (int unsigned k = t_rise; k < m_cyc; k++) sum += int'(lvl_hist[k[11:0]]);
            e_duty = DUTY_W'(sum);
            e_vld  = 1'b1;
          end else begin
            e_err = 1'b1;
          end
          t_rise = m_cyc;
        end else if (m_cyc - t_rise == PU) begin
          e_err     = 1'b1;
          measuring = 1'b0;
          run_ok    = 1'b0;
        end
      end else if (lv && !pv) begin
        measuring = 1'b1;
        t_rise    = m_cyc;
      end else begin
        if (!run_ok || lv != run_lvl) begin
          run_ok    = 1'b1;
          run_start = m_cyc;
          run_lvl   = lv;
        end
        if (m_cyc - run_start + 1 == PU) begin
          if (lv) e_err = 1'b1;
          else begin
            e_vld  = 1'b1;
            e_duty = '0;
          end
          run_ok = 1'b0;
        end
      end
    end
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
    vectors++;
    if (duty !== e_duty || vld !== e_vld || err !== e_err) begin
      miscompares++;
      if (nprint < 20)
        $display("FAIL model_cycle t=%0t duty=%0d/%0d vld=%0b/%0b err=%0b/%0b (actual/required)",
                 $time, duty, e_duty, vld, e_vld, err, e_err);
      nprint++;
    end
    if (vld === 1'b1) n_vld++;
    if (err === 1'b1) n_err++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    PWM_in = lvl;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit do_rst;
    int period;
    int high;
    int nper;
    int exp_vld;
    int exp_err;
    int exp_duty;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int lat, vidx, eidx, v1, v2, kind, len, hi;

    tbl[0] = '{1'b1, 2048, 1024, 2, 2, 0, 1024};
    tbl[1] = '{1'b1, 2048, 2047, 2, 2, 0, 2047};
    tbl[2] = '{1'b0, 2048,    1, 2, 2, 1,    1};
    tbl[3] = '{1'b1, 2048,  700, 2, 2, 0,  700};
    tbl[4] = '{1'b0, 1000,  500, 4, 0, 5,  700};
    tbl[5] = '{1'b1, 2048, 2046, 2, 2, 0, 2046};

    do_reset();
    check("reset_duty", int'(duty), 0);
    check("reset_vld", int'(vld), 0);
    check("reset_err", int'(err), 0);

    foreach (tbl[i]) begin
      n_vld = 0;
      n_err = 0;
      if (tbl[i].do_rst) do_reset();
      drive(1'b0, 8);
      for (int p = 0; p < tbl[i].nper; p++) begin
        drive(1'b1, tbl[i].high);
        drive(1'b0, tbl[i].period - tbl[i].high);
      end
      drive(1'b1, 6);
      check($sformatf("tbl%0d_vld_count", i), n_vld, tbl[i].exp_vld);
      check($sformatf("tbl%0d_err_count", i), n_err, tbl[i].exp_err);
      check($sformatf("tbl%0d_duty", i), int'(duty), tbl[i].exp_duty);
    end

    // Latency from the PWM_in rise that closes a valid period to vld.
    do_reset();
    drive(1'b0, 8);
    drive(1'b1, 1024);
    drive(1'b0, 1024);
    PWM_in = 1'b1;
    lat = 0;
    while (lat < 10 && vld !== 1'b1) begin
      tick();
      lat++;
    end
    check("vld_latency", lat, 3);
    check("latency_duty", int'(duty), 1024);

    // Reset in the low part of a duty-700 period, then a held-high line.
    do_reset();
    drive(1'b0, 8);
    drive(1'b1, 700);
    drive(1'b0, P - 700);
    drive(1'b1, 700);
    drive(1'b0, 800);
    check("pre_reset_duty", int'(duty), 700);
    do_reset();
    check("post_reset_duty", int'(duty), 0);
    check("post_reset_vld", int'(vld), 0);
    n_vld = 0;
    n_err = 0;
    drive(1'b0, P - 700 - 800);
    drive(1'b1, 700);
    drive(1'b0, P - 700);
    check("no_vld_after_phase_rise", n_vld, 0);
    PWM_in = 1'b1;
    vidx = 0;
    eidx = 0;
    for (int i = 1; i <= 3000; i++) begin
      tick();
      if (vld === 1'b1 && vidx == 0) vidx = i;
      if (err === 1'b1 && eidx == 0) eidx = i;
    end
    check("reset_recover_vld_tick", vidx, 3);
    check("held_high_err_count", n_err, 1);
    check("held_high_err_tick", eidx, P + 3);
    check("held_high_duty", int'(duty), 700);
    check("held_high_vld_count", n_vld, 1);

    // Line held low from reset: duty 0 reported every full period.
    PWM_in = 1'b0;
    do_reset();
    n_vld = 0;
    n_err = 0;
    v1 = 0;
    v2 = 0;
    for (int i = 1; i <= 4200; i++) begin
      tick();
      if (vld === 1'b1) begin
        if (v1 == 0) v1 = i;
        else if (v2 == 0) v2 = i;
      end
    end
    check("low_first_vld_tick", v1, P);
    check("low_second_vld_tick", v2, 2 * P);
    check("low_vld_count", n_vld, 2);
    check("low_err_count", n_err, 0);
    check("low_duty", int'(duty), 0);

    // Next rise 2100 clocks after the last: overrun error, no decode.
    n_vld = 0;
    n_err = 0;
    drive(1'b1, 1000);
    drive(1'b0, 1100);
    drive(1'b1, 5);
    check("overrun_err_count", n_err, 1);
    check("overrun_vld_count", n_vld, 0);

    // Random waveform segments against the reference model.
    do_reset();
    for (int sgi = 0; sgi < 14; sgi++) begin
      kind = int'($urandom_range(0, 9));
      case (kind)
        0, 1, 2, 3, 4, 5: begin
          hi = int'($urandom_range(1, P - 1));
          drive(1'b1, hi);
          drive(1'b0, P - hi);
        end
        6: begin
          len = int'($urandom_range(300, 2600));
          hi  = int'($urandom_range(1, len - 1));
          drive(1'b1, hi);
          drive(1'b0, len - hi);
        end
        7: drive(1'b0, int'($urandom_range(1000, 2600)));
        8: drive(1'b1, int'($urandom_range(500, 2600)));
        default: begin
          PWM_in = 1'b0;
          do_reset();
          drive(1'b0, 5);
        end
      endcase
    end
    drive(1'b0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
